// File: rtl/class_result_buffer_if.sv
// Sample-in / result-out bus of the class result buffer.
// class_valid is a push with no ready: a write offered while the FIFO is full and
// not popping in the same cycle is dropped, and the drop is flagged by overflow.
// rd_en is a pop request; rd_valid pulses for one cycle, one cycle after an accepted pop.
interface class_result_buffer_if #(
    parameter int IDX_W = 7
);
    logic              class_valid;
    logic signed [1:0] class_in;
    logic              rd_en;
    logic [IDX_W+1:0]  rd_data;
    logic              rd_valid;

    modport master (
        output class_valid, class_in, rd_en,
        input  rd_data, rd_valid
    );

    modport slave (
        input  class_valid, class_in, rd_en,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/class_result_buffer.sv
// Buffers per-sample SVM class decisions as {index, class} in a FIFO and keeps
// saturating per-class tallies plus a combinational majority vote.
module class_result_buffer #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 7,
    parameter int CNT_W = 7
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    class_result_buffer_if.slave     bus,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         pos_cnt,
    output logic [CNT_W-1:0]         neg_cnt,
    output logic [CNT_W-1:0]         und_cnt,
    output logic signed [1:0]        majority,
    output logic                     overflow,
    output logic                     illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = IDX_W + 2;
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [DW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] pos_q, pos_d, neg_q, neg_d, und_q, und_d;
    logic [DW-1:0]    rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d, illegal_q, illegal_d;
    logic             pop, push, mem_we;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        idx_d      = idx_q;
        pos_d      = pos_q;
        neg_d      = neg_q;
        und_d      = und_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        mem_we     = 1'b0;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts a write
        // when it is also being read; an empty FIFO never pops (no fall-through).
        pop  = bus.rd_en && (level_q != '0);
        push = bus.class_valid && ((level_q != FULL_LVL) || pop);

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            idx_d      = '0;
            pos_d      = '0;
            neg_d      = '0;
            und_d      = '0;
            overflow_d = 1'b0;
            illegal_d  = 1'b0;
        end else begin
            if (pop) begin
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + AW'(1);
            end
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                idx_d    = idx_q + IDX_W'(1);
                case (bus.class_in)
                    2'b01:   pos_d = sat_inc(pos_q);
                    2'b11:   neg_d = sat_inc(neg_q);
                    2'b10: begin
                        und_d     = sat_inc(und_q);
                        illegal_d = 1'b1;
                    end
                    default: und_d = sat_inc(und_q);
                endcase
            end else if (bus.class_valid) begin
                overflow_d = 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + (AW+1)'(1);
            end else if (pop && !push) begin
                level_d = level_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            idx_q      <= '0;
            pos_q      <= '0;
            neg_q      <= '0;
            und_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            neg_q      <= neg_d;
            und_q      <= und_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {idx_q, bus.class_in};
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign level        = level_q;
    assign full         = (level_q == FULL_LVL);
    assign empty        = (level_q == '0);
    assign pos_cnt      = pos_q;
    assign neg_cnt      = neg_q;
    assign und_cnt      = und_q;
    assign overflow     = overflow_q;
    assign illegal      = illegal_q;
    assign majority     = (pos_q > neg_q) ? 2'sb01 :
                          (neg_q > pos_q) ? 2'sb11 : 2'sb00;
endmodule
